// File: rtl/robin_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding and host command codes.
package robin_pkg;

    typedef enum logic [2:0] {
        CPU_RUN    = 3'd0,
        HALT_WAIT  = 3'd1,
        HOST_IDLE  = 3'd2,
        HOST_READ1 = 3'd3,
        HOST_READ2 = 3'd4,
        HOST_WRITE = 3'd5,
        RESTART    = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        CMD_READ  = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_RUN   = 2'd2,
        CMD_STOP  = 2'd3
    } host_cmd_t;

    // The CPU drives the RAM port only while it runs or is being asked to halt.
    function automatic logic cpu_owns(input state_t s);
        return (s == CPU_RUN) || (s == HALT_WAIT);
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port-pair RAM between a CPU and a host debug port.
// The host halts the CPU before touching RAM, and can restart it at any address.
module mem_arbiter
    import robin_pkg::*;
#(
    parameter int addr_width = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    // CPU side
    input  logic [addr_width-1:0] cpu_raddr,
    input  logic [addr_width-1:0] cpu_waddr,
    input  logic                  cpu_write,
    input  logic [7:0]            cpu_data_in,
    output logic [7:0]            cpu_data_out,
    output logic                  cpu_halt,
    input  logic                  cpu_halted,
    output logic                  cpu_reset,
    output logic [addr_width-1:0] cpu_start_address,
    // RAM side
    output logic [addr_width-1:0] ram_raddr,
    output logic [addr_width-1:0] ram_waddr,
    output logic                  ram_write,
    output logic [7:0]            ram_data_in,
    input  logic [7:0]            ram_data_out,
    // Host side
    input  logic                  host_req,
    input  logic [1:0]            host_cmd,
    input  logic [addr_width-1:0] host_addr,
    input  logic [7:0]            host_wdata,
    output logic                  host_ack,
    output logic [7:0]            host_rdata,
    output logic                  host_owner
);

    state_t                  state_reg,   state_next;
    host_cmd_t               cmd_reg,     cmd_next;
    logic [addr_width-1:0]   addr_reg,    addr_next;
    logic [7:0]              wdata_reg,   wdata_next;
    logic [addr_width-1:0]   start_reg,   start_next;
    logic [7:0]              rdata_reg,   rdata_next;
    logic                    ack_reg,     ack_next;
    logic                    pending_reg, pending_next;
    logic                    accept;

    // Read data goes straight back to the CPU regardless of ownership.
    assign cpu_data_out = ram_data_out;

    // State and host-side register update; reset discards any in-flight request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= HOST_IDLE;
            cmd_reg     <= CMD_READ;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            start_reg   <= '0;
            rdata_reg   <= '0;
            ack_reg     <= 1'b0;
            pending_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cmd_reg     <= cmd_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            start_reg   <= start_next;
            rdata_reg   <= rdata_next;
            ack_reg     <= ack_next;
            pending_reg <= pending_next;
        end
    end

    // Next-state logic: request acceptance, command latching and sequencing.
    always_comb begin
        state_next   = state_reg;
        cmd_next     = cmd_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        start_next   = start_reg;
        rdata_next   = rdata_reg;
        ack_next     = 1'b0;
        pending_next = pending_reg;

        // The ack-cycle guard stops a still-held host_req from being taken twice.
        accept = host_req && !ack_reg &&
                 ((state_reg == CPU_RUN) || ((state_reg == HOST_IDLE) && !pending_reg));

        if (accept) begin
            cmd_next   = host_cmd_t'(host_cmd);
            addr_next  = host_addr;
            wdata_next = host_wdata;
            if (host_cmd_t'(host_cmd) == CMD_RUN)
                start_next = host_addr;
        end

        case (state_reg)
            CPU_RUN: begin
                if (accept)
                    state_next = (host_cmd_t'(host_cmd) == CMD_RUN) ? RESTART : HALT_WAIT;
            end
            HALT_WAIT: begin
                // A STOP is finished once the CPU is halted; READ/WRITE run from HOST_IDLE.
                if (cpu_halted) begin
                    state_next = HOST_IDLE;
                    if (cmd_reg == CMD_STOP)
                        ack_next = 1'b1;
                    else
                        pending_next = 1'b1;
                end
            end
            HOST_IDLE: begin
                if (pending_reg) begin
                    pending_next = 1'b0;
                    state_next   = (cmd_reg == CMD_READ) ? HOST_READ1 : HOST_WRITE;
                end else if (accept) begin
                    case (host_cmd_t'(host_cmd))
                        CMD_READ:  state_next = HOST_READ1;
                        CMD_WRITE: state_next = HOST_WRITE;
                        CMD_RUN:   state_next = RESTART;
                        CMD_STOP:  ack_next   = 1'b1;
                        default:   state_next = HOST_IDLE;
                    endcase
                end
            end
            HOST_READ1: state_next = HOST_READ2;
            HOST_READ2: begin
                rdata_next = ram_data_out;
                ack_next   = 1'b1;
                state_next = HOST_IDLE;
            end
            HOST_WRITE: begin
                ack_next   = 1'b1;
                state_next = HOST_IDLE;
            end
            RESTART: begin
                ack_next   = 1'b1;
                state_next = CPU_RUN;
            end
            default: state_next = HOST_IDLE;
        endcase
    end

    // Output logic: RAM port mux, CPU control and host status.
    always_comb begin
        host_owner        = !cpu_owns(state_reg);
        cpu_halt          = !((state_reg == CPU_RUN) || (state_reg == RESTART));
        cpu_reset         = reset || (state_reg == RESTART);
        cpu_start_address = start_reg;
        host_ack          = ack_reg;
        host_rdata        = rdata_reg;
        if (cpu_owns(state_reg)) begin
            ram_raddr   = cpu_raddr;
            ram_waddr   = cpu_waddr;
            ram_write   = cpu_write;
            ram_data_in = cpu_data_in;
        end else begin
            ram_raddr   = addr_reg;
            ram_waddr   = addr_reg;
            ram_write   = (state_reg == HOST_WRITE);
            ram_data_in = wdata_reg;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a registered-read RAM model.
module tb_mem_arbiter;

    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] cpu_raddr, cpu_waddr;
    logic          cpu_write;
    logic [7:0]    cpu_data_in, cpu_data_out;
    logic          cpu_halt, cpu_halted, cpu_reset;
    logic [AW-1:0] cpu_start_address;
    logic [AW-1:0] ram_raddr, ram_waddr;
    logic          ram_write;
    logic [7:0]    ram_data_in, ram_data_out;
    logic          host_req;
    logic [1:0]    host_cmd;
    logic [AW-1:0] host_addr;
    logic [7:0]    host_wdata;
    logic          host_ack;
    logic [7:0]    host_rdata;
    logic          host_owner;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.addr_width(AW)) dut (
        .clk(clk), .reset(reset),
        .cpu_raddr(cpu_raddr), .cpu_waddr(cpu_waddr), .cpu_write(cpu_write),
        .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out),
        .cpu_halt(cpu_halt), .cpu_halted(cpu_halted), .cpu_reset(cpu_reset),
        .cpu_start_address(cpu_start_address),
        .ram_raddr(ram_raddr), .ram_waddr(ram_waddr), .ram_write(ram_write),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
        .host_req(host_req), .host_cmd(host_cmd), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .host_owner(host_owner)
    );

    // RAM model: address presented in one cycle, data registered for the next.
    logic [7:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_write)
            mem[ram_waddr] <= ram_data_in;
        ram_data_out <= mem[ram_raddr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input logic [1:0] cmd, input logic [AW-1:0] addr, input logic [7:0] wd);
        host_req   = 1'b1;
        host_cmd   = cmd;
        host_addr  = addr;
        host_wdata = wd;
    endtask

    initial begin
        int hw_cycles;
        int acks;
        int ack_k;
        logic [7:0] got_rdata;

        reset = 1'b1;
        cpu_raddr = '0; cpu_waddr = '0; cpu_write = 1'b0; cpu_data_in = '0;
        cpu_halted = 1'b0;
        host_req = 1'b0; host_cmd = '0; host_addr = '0; host_wdata = '0;

        // Reset
        repeat (3) @(negedge clk);
        check("rst_cpu_reset_high", cpu_reset, 1);
        reset = 1'b0;
        @(negedge clk);
        check("rst_owner", host_owner, 1);
        check("rst_cpu_halt", cpu_halt, 1);
        check("rst_cpu_reset_low", cpu_reset, 0);
        check("rst_start", cpu_start_address, 0);
        check("rst_ack", host_ack, 0);
        check("rst_rdata", host_rdata, 0);
        check("rst_ram_write", ram_write, 0);
        $display("txn reset done");

        // Host WRITE 0x010 <- 0xA5
        drive_req(2'd1, 9'h010, 8'hA5);
        @(negedge clk);
        check("wr_ram_write", ram_write, 1);
        check("wr_waddr", ram_waddr, 9'h010);
        check("wr_data", ram_data_in, 8'hA5);
        check("wr_ack_early", host_ack, 0);
        check("wr_halt", cpu_halt, 1);
        host_req = 1'b0;
        @(negedge clk);
        check("wr_ack", host_ack, 1);
        check("wr_ram_write_off", ram_write, 0);
        check("wr_halt_after", cpu_halt, 1);
        @(negedge clk);
        check("wr_ack_single", host_ack, 0);
        $display("txn WRITE addr=0x010 data=0xa5");

        // Host READ 0x010, held until ack; request inputs change after acceptance
        drive_req(2'd0, 9'h010, 8'h00);
        @(negedge clk);
        host_addr = 9'h1FF;
        check("rd1_raddr", ram_raddr, 9'h010);
        check("rd1_ack", host_ack, 0);
        @(negedge clk);
        check("rd2_raddr", ram_raddr, 9'h010);
        check("rd2_ack", host_ack, 0);
        @(negedge clk);
        check("rd_ack", host_ack, 1);
        check("rd_rdata", host_rdata, 8'hA5);
        host_req = 1'b0;
        @(negedge clk);
        check("rd_ack_single", host_ack, 0);
        check("rd_rdata_hold", host_rdata, 8'hA5);
        $display("txn READ addr=0x010 rdata=0x%0h", host_rdata);

        // STOP while host owns RAM: immediate ack
        drive_req(2'd3, 9'h000, 8'h00);
        @(negedge clk);
        check("stop_ack", host_ack, 1);
        check("stop_owner", host_owner, 1);
        host_req = 1'b0;
        @(negedge clk);
        check("stop_ack_single", host_ack, 0);
        $display("txn STOP in host idle");

        // RUN at 0x020
        drive_req(2'd2, 9'h020, 8'h00);
        @(negedge clk);
        check("run_cpu_reset", cpu_reset, 1);
        check("run_start", cpu_start_address, 9'h020);
        check("run_halt", cpu_halt, 0);
        check("run_ack_early", host_ack, 0);
        host_req = 1'b0;
        @(negedge clk);
        check("run_ack", host_ack, 1);
        check("run_cpu_reset_off", cpu_reset, 0);
        check("run_owner", host_owner, 0);
        check("run_halt_after", cpu_halt, 0);
        // CPU traffic passes straight through
        cpu_waddr = 9'h100; cpu_data_in = 8'h3C; cpu_write = 1'b1; cpu_raddr = 9'h055;
        #1;
        check("cpu_ram_write", ram_write, 1);
        check("cpu_ram_waddr", ram_waddr, 9'h100);
        check("cpu_ram_data", ram_data_in, 8'h3C);
        check("cpu_ram_raddr", ram_raddr, 9'h055);
        @(negedge clk);
        cpu_write = 1'b0;
        check("run_ack_single", host_ack, 0);
        check("cpu_write_landed", mem[9'h100], 8'h3C);
        $display("txn RUN addr=0x020, CPU wrote 0x3c@0x100");

        // READ while CPU runs; CPU halts two cycles after the request is accepted
        drive_req(2'd0, 9'h100, 8'h00);
        hw_cycles = 0; acks = 0; ack_k = 0; got_rdata = 8'h00;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (host_owner == 1'b0 && cpu_halt == 1'b1) hw_cycles++;
            if (host_ack) begin
                acks++;
                ack_k = k;
                got_rdata = host_rdata;
                host_req = 1'b0;
            end
            if (k == 2) cpu_halted = 1'b1;
        end
        host_req = 1'b0;
        check("hw_cycles", hw_cycles, 2);
        check("hw_ack_count", acks, 1);
        check("hw_ack_cycle", ack_k, 6);
        check("hw_rdata", got_rdata, 8'h3C);
        check("hw_owner", host_owner, 1);
        $display("txn READ during run addr=0x100 rdata=0x%0h halt_wait=%0d", got_rdata, hw_cycles);

        // Reset lands while the read is in HOST_READ2
        drive_req(2'd0, 9'h010, 8'h00);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mr_ack", host_ack, 0);
        check("mr_owner", host_owner, 1);
        check("mr_halt", cpu_halt, 1);
        check("mr_cpu_reset", cpu_reset, 1);
        check("mr_rdata", host_rdata, 0);
        check("mr_start", cpu_start_address, 0);
        check("mr_ram_write", ram_write, 0);
        host_req = 1'b0;
        reset = 1'b0;
        acks = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (host_ack) acks++;
        end
        check("mr_no_late_ack", acks, 0);
        check("mr_cpu_reset_off", cpu_reset, 0);
        $display("txn reset during read, request discarded");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
